// File: rtl/hazard_control_unit_if.sv
// Pipeline control bundle between the hazard control unit and the core.
// master: core side; drives stage status, receives control strobes.
// slave : hazard_control_unit side.
//   Stage status : id_valid, id_rs1/2, id_uses_rs1/2, ex_mem_read, ex_rd,
//                  ex_muldiv, ex_branch_taken, ex_branch_target, mem_req,
//                  mem_ready, cnt_clear
//   Controls     : pc_src, dest_pc, pc_write_zero, IF_pipeline_write_zero,
//                  if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold,
//                  ex_mem_bubble, mem_wb_bubble, stall_cnt, flush_cnt
interface hazard_control_unit_if #(
   parameter int PC_W   = 16,
   parameter int REG_AW = 5
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_uses_rs1;
   logic              id_uses_rs2;
   logic              ex_mem_read;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_muldiv;
   logic              ex_branch_taken;
   logic [PC_W-1:0]   ex_branch_target;
   logic              mem_req;
   logic              mem_ready;
   logic              cnt_clear;

   logic              pc_src;
   logic [PC_W-1:0]   dest_pc;
   logic              pc_write_zero;
   logic              IF_pipeline_write_zero;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              id_ex_hold;
   logic              ex_mem_hold;
   logic              ex_mem_bubble;
   logic              mem_wb_bubble;
   logic [15:0]       stall_cnt;
   logic [15:0]       flush_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_mem_read, ex_rd, ex_muldiv, ex_branch_taken,
             ex_branch_target, mem_req, mem_ready, cnt_clear,
      input  pc_src, dest_pc, pc_write_zero, IF_pipeline_write_zero,
             if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold,
             ex_mem_bubble, mem_wb_bubble, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_mem_read, ex_rd, ex_muldiv, ex_branch_taken,
             ex_branch_target, mem_req, mem_ready, cnt_clear,
      output pc_src, dest_pc, pc_write_zero, IF_pipeline_write_zero,
             if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold,
             ex_mem_bubble, mem_wb_bubble, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_control_unit.sv
// Central pipeline sequencer: resolves load-use hazards, taken-branch
// redirects, multi-cycle mul/div occupancy of EX and data-memory wait
// states, and keeps saturating stall/flush counters.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   hz    - hazard_control_unit_if.slave (stage status in, controls out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RUN     | normal flow; rules evaluated in priority order
// S_MD_BUSY | mul/div occupying EX; md_cnt_q counts remaining hold cycles
// S_MEM_WAIT| data memory access pending; whole front end frozen
module hazard_control_unit #(
   parameter int PC_W          = 16,
   parameter int REG_AW        = 5,
   parameter int MULDIV_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_control_unit_if.slave hz
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MD_BUSY  = 2'd1,
      S_MEM_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] MD_LOAD   = 8'(MULDIV_CYCLES - 1);
   localparam bit         MD_STALLS = (MULDIV_CYCLES > 1);

   state_t      state_q, state_d;
   logic [7:0]  md_cnt_q, md_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   logic            pc_src;
   logic [PC_W-1:0] dest_pc;
   logic            pc_write_zero;
   logic            if_write_zero;
   logic            if_id_flush;
   logic            id_ex_flush;
   logic            id_ex_hold;
   logic            ex_mem_hold;
   logic            ex_mem_bubble;
   logic            mem_wb_bubble;

   logic load_use;
   logic mem_rule;
   logic md_hold;
   logic md_start;

   assign load_use = hz.id_valid && hz.ex_mem_read && (hz.ex_rd != {REG_AW{1'b0}}) &&
                     ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                      (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

   // MEM is bubbled during MD_BUSY, so mem_req is only looked at in RUN
   // and MEM_WAIT.
   assign mem_rule = ((state_q == S_RUN) && hz.mem_req && !hz.mem_ready) ||
                     ((state_q == S_MEM_WAIT) && !hz.mem_ready);
   assign md_hold  = (state_q == S_MD_BUSY) && (md_cnt_q != 8'd1);
   // The release cycle of MD_BUSY must not restart the same mul/div.
   assign md_start = MD_STALLS && hz.ex_muldiv && (state_q != S_MD_BUSY);

   always_comb begin
      state_d       = S_RUN;
      md_cnt_d      = md_cnt_q;
      pc_src        = 1'b0;
      dest_pc       = '0;
      pc_write_zero = 1'b0;
      if_write_zero = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      id_ex_hold    = 1'b0;
      ex_mem_hold   = 1'b0;
      ex_mem_bubble = 1'b0;
      mem_wb_bubble = 1'b0;

      if (mem_rule) begin
         pc_write_zero = 1'b1;
         if_write_zero = 1'b1;
         id_ex_hold    = 1'b1;
         ex_mem_hold   = 1'b1;
         mem_wb_bubble = 1'b1;
         state_d       = S_MEM_WAIT;
      end else if (md_hold || md_start) begin
         pc_write_zero = 1'b1;
         if_write_zero = 1'b1;
         id_ex_hold    = 1'b1;
         ex_mem_bubble = 1'b1;
         state_d       = S_MD_BUSY;
         md_cnt_d      = md_hold ? (md_cnt_q - 8'd1) : MD_LOAD;
      end else if (hz.ex_branch_taken) begin
         pc_src      = 1'b1;
         dest_pc     = hz.ex_branch_target;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_write_zero = 1'b1;
         if_write_zero = 1'b1;
         id_ex_flush   = 1'b1;
      end

      if (reset) begin
         pc_src        = 1'b0;
         dest_pc       = '0;
         pc_write_zero = 1'b0;
         if_write_zero = 1'b0;
         if_id_flush   = 1'b0;
         id_ex_flush   = 1'b0;
         id_ex_hold    = 1'b0;
         ex_mem_hold   = 1'b0;
         ex_mem_bubble = 1'b0;
         mem_wb_bubble = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hz.cnt_clear) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (pc_write_zero && !pc_src && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
         if (pc_src && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_RUN;
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.pc_src                 = pc_src;
   assign hz.dest_pc                = dest_pc;
   assign hz.pc_write_zero          = pc_write_zero;
   assign hz.IF_pipeline_write_zero = if_write_zero;
   assign hz.if_id_flush            = if_id_flush;
   assign hz.id_ex_flush            = id_ex_flush;
   assign hz.id_ex_hold             = id_ex_hold;
   assign hz.ex_mem_hold            = ex_mem_hold;
   assign hz.ex_mem_bubble          = ex_mem_bubble;
   assign hz.mem_wb_bubble          = mem_wb_bubble;
   assign hz.stall_cnt              = stall_cnt_q;
   assign hz.flush_cnt              = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

   // ctl bit order: pc_src, pc_write_zero, IF_pipeline_write_zero,
   // if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold, ex_mem_bubble,
   // mem_wb_bubble
   localparam logic [8:0] C_NONE = 9'b0_00_00_00_00;
   localparam logic [8:0] C_MEM  = 9'b0_11_00_11_01;
   localparam logic [8:0] C_MD   = 9'b0_11_00_10_10;
   localparam logic [8:0] C_BR   = 9'b1_00_11_00_00;
   localparam logic [8:0] C_LU   = 9'b0_11_01_00_00;

   typedef struct {
      logic [8:0]  ctl;
      logic [15:0] pc;
      logic [15:0] stall;
      logic [15:0] flush;
      string       name;
   } exp_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   hazard_control_unit_if #(.PC_W(16), .REG_AW(5)) hz();

   hazard_control_unit #(.PC_W(16), .REG_AW(5), .MULDIV_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expectation per checked cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [8:0] act;
         e   = sb.pop_front();
         act = {hz.pc_src, hz.pc_write_zero, hz.IF_pipeline_write_zero,
                hz.if_id_flush, hz.id_ex_flush, hz.id_ex_hold,
                hz.ex_mem_hold, hz.ex_mem_bubble, hz.mem_wb_bubble};
         checks++;
         if (act !== e.ctl) begin
            errors++;
            $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
         end
         checks++;
         if (hz.dest_pc !== e.pc) begin
            errors++;
            $display("FAIL %s dest_pc: got %h expected %h", e.name, hz.dest_pc, e.pc);
         end
         checks++;
         if (hz.stall_cnt !== e.stall) begin
            errors++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, hz.stall_cnt, e.stall);
         end
         checks++;
         if (hz.flush_cnt !== e.flush) begin
            errors++;
            $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, hz.flush_cnt, e.flush);
         end
      end
   end

   task automatic idle();
      hz.id_valid         = 1'b0;
      hz.id_rs1           = '0;
      hz.id_rs2           = '0;
      hz.id_uses_rs1      = 1'b0;
      hz.id_uses_rs2      = 1'b0;
      hz.ex_mem_read      = 1'b0;
      hz.ex_rd            = '0;
      hz.ex_muldiv        = 1'b0;
      hz.ex_branch_taken  = 1'b0;
      hz.ex_branch_target = '0;
      hz.mem_req          = 1'b0;
      hz.mem_ready        = 1'b0;
      hz.cnt_clear        = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2);
      hz.id_valid    = 1'b1;
      hz.ex_mem_read = 1'b1;
      hz.ex_rd       = rd;
      hz.id_rs1      = rs1;
      hz.id_uses_rs1 = u1;
      hz.id_rs2      = rs2;
      hz.id_uses_rs2 = u2;
   endtask

   task automatic branch(input logic [15:0] tgt);
      hz.ex_branch_taken  = 1'b1;
      hz.ex_branch_target = tgt;
   endtask

   // Inputs are already applied for this cycle; record expectation, advance.
   task automatic cyc(input logic [8:0] ctl, input logic [15:0] pc,
                      input logic [15:0] s, input logic [15:0] f, input string name);
      exp_t e;
      e.ctl   = ctl;
      e.pc    = pc;
      e.stall = s;
      e.flush = f;
      e.name  = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      hz.mem_req = 1'b1; hz.mem_ready = 1'b0; branch(16'h1234);
      cyc(C_NONE, 16'h0, 0, 0, "reset_forces_zero");
      reset = 1'b0; idle();
      cyc(C_NONE, 16'h0, 0, 0, "idle");

      load_use(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
      cyc(C_LU, 16'h0, 0, 0, "lu_rs2");
      idle();
      cyc(C_NONE, 16'h0, 1, 0, "lu_single_bubble");
      load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
      cyc(C_LU, 16'h0, 1, 0, "lu_rs1");
      load_use(5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
      cyc(C_NONE, 16'h0, 2, 0, "lu_rs1_unused");
      load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      cyc(C_NONE, 16'h0, 2, 0, "lu_rd_zero");
      load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); hz.id_valid = 1'b0;
      cyc(C_NONE, 16'h0, 2, 0, "lu_id_invalid");

      idle(); branch(16'h0040);
      cyc(C_BR, 16'h0040, 2, 0, "branch");
      load_use(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); branch(16'h0080);
      cyc(C_BR, 16'h0080, 2, 1, "branch_masks_lu");
      idle();
      cyc(C_NONE, 16'h0, 2, 2, "after_branch");

      hz.ex_muldiv = 1'b1;
      cyc(C_MD, 16'h0, 2, 2, "md_start");
      hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
      cyc(C_MD, 16'h0, 3, 2, "md_hold2_memreq_ignored");
      hz.mem_req = 1'b0;
      cyc(C_MD, 16'h0, 4, 2, "md_hold3");
      cyc(C_NONE, 16'h0, 5, 2, "md_release");
      hz.ex_muldiv = 1'b0;
      cyc(C_NONE, 16'h0, 5, 2, "md_after");

      idle(); hz.mem_req = 1'b1; hz.mem_ready = 1'b0; branch(16'h0100);
      cyc(C_MEM, 16'h0, 5, 2, "mem_wait1");
      cyc(C_MEM, 16'h0, 6, 2, "mem_wait2");
      cyc(C_MEM, 16'h0, 7, 2, "mem_wait3");
      hz.mem_ready = 1'b1;
      cyc(C_BR, 16'h0100, 8, 2, "mem_ready_branch");
      idle();
      cyc(C_NONE, 16'h0, 8, 3, "after_mem");

      hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
      cyc(C_MEM, 16'h0, 8, 3, "mem_then_md_wait");
      hz.mem_ready = 1'b1; hz.ex_muldiv = 1'b1;
      cyc(C_MD, 16'h0, 9, 3, "mem_ready_md_start");
      hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
      cyc(C_MD, 16'h0, 10, 3, "md2_hold2");
      cyc(C_MD, 16'h0, 11, 3, "md2_hold3");
      cyc(C_NONE, 16'h0, 12, 3, "md2_release");
      hz.ex_muldiv = 1'b0;
      cyc(C_NONE, 16'h0, 12, 3, "md2_after");

      hz.ex_muldiv = 1'b1;
      cyc(C_MD, 16'h0, 12, 3, "md3_start");
      reset = 1'b1;
      cyc(C_NONE, 16'h0, 13, 3, "reset_in_md_busy");
      reset = 1'b0; hz.ex_muldiv = 1'b0; branch(16'h0200);
      cyc(C_BR, 16'h0200, 0, 0, "run_after_reset");
      idle();
      cyc(C_NONE, 16'h0, 0, 1, "post_reset_idle");

      hz.cnt_clear = 1'b1;
      cyc(C_NONE, 16'h0, 0, 1, "clear_cycle");
      hz.cnt_clear = 1'b0;
      cyc(C_NONE, 16'h0, 0, 0, "cleared_flush");
      branch(16'h0010); hz.cnt_clear = 1'b1;
      cyc(C_BR, 16'h0010, 0, 0, "clear_with_branch");
      idle();
      cyc(C_NONE, 16'h0, 0, 0, "clear_beats_inc");

      hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
      repeat (65540) @(posedge clk);
      #1;
      cyc(C_MEM, 16'h0, 16'hFFFF, 0, "sat_hold");
      hz.cnt_clear = 1'b1;
      cyc(C_MEM, 16'h0, 16'hFFFF, 0, "sat_clear_cycle");
      hz.cnt_clear = 1'b0;
      cyc(C_MEM, 16'h0, 16'h0000, 0, "sat_cleared");
      cyc(C_MEM, 16'h0, 16'h0001, 0, "sat_recount");
      hz.mem_ready = 1'b1;
      cyc(C_NONE, 16'h0, 16'h0002, 0, "sat_release");
      idle();
      cyc(C_NONE, 16'h0, 16'h0002, 0, "final_idle");

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central pipeline sequencer for the 5-stage core. It drives the IF stage controls (pc_src, dest_pc, pc_write_zero, IF_pipeline_write_zero) and the hold, flush and bubble strobes of the later pipeline registers.
- It resolves four conditions:
  - load-use hazards;
  - taken-branch redirects;
  - multi-cycle mul/div occupancy of EX;
  - data-memory wait states.
- It also keeps saturating stall and flush performance counters.

Parameters:
- PC_W, 16: width of dest_pc and ex_branch_target.
- REG_AW, 5: register address width.
- MULDIV_CYCLES, 4: total EX occupancy of a mul/div instruction in cycles; legal range is 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1, id_rs2  in  REG_AW  ID source register addresses.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1 / rs2.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  EX destination register.
- ex_muldiv  in  1  EX instruction is mul/div.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- ex_branch_target  in  PC_W  redirect address.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- cnt_clear  in  1  synchronous clear of both counters.
- pc_src  out  1  select dest_pc as next PC.
- dest_pc  out  PC_W  redirect target; equals 0 when pc_src=0.
- pc_write_zero  out  1  1 = PC holds its value.
- IF_pipeline_write_zero  out  1  1 = IF/ID register holds its value.
- if_id_flush, id_ex_flush  out  1  load a bubble into that register.
- id_ex_hold, ex_mem_hold  out  1  freeze that register.
- ex_mem_bubble, mem_wb_bubble  out  1  insert a bubble into that register.
- stall_cnt, flush_cnt  out  16  performance counters.

Behaviour:
- FSM states: RUN, MD_BUSY, MEM_WAIT. There is also an 8-bit down-counter md_cnt.
- Control outputs are combinational from state and inputs.
- While reset=1: all control outputs are 0, the FSM goes to RUN, and md_cnt, stall_cnt and flush_cnt all go to 0. This applies mid-operation too: reset aborts MD_BUSY or MEM_WAIT on the next edge.
- RUN evaluates rules in priority order; the first matching rule wins:
  1. Mem stall (mem_req & !mem_ready): pc_write_zero=1, IF_pipeline_write_zero=1, id_ex_hold=1, ex_mem_hold=1, mem_wb_bubble=1. Any branch is ignored because it stays held in EX. Next state is MEM_WAIT.
  2. Mul/div (ex_muldiv & MULDIV_CYCLES>1): pc_write_zero=1, IF_pipeline_write_zero=1, id_ex_hold=1, ex_mem_bubble=1. Load md_cnt=MULDIV_CYCLES-1. Next state is MD_BUSY.
  3. Taken branch: pc_src=1, dest_pc=ex_branch_target, if_id_flush=1, id_ex_flush=1, flush_cnt+1. The redirect is zero-latency, in the same cycle.
  4. Load-use: id_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Outputs: pc_write_zero=1, IF_pipeline_write_zero=1, id_ex_flush=1. This is exactly one bubble per hazard.
  5. Otherwise all controls are 0.
- MD_BUSY:
  - If md_cnt!=1: same holds as rule 2, md_cnt-1.
  - If md_cnt==1 (release cycle): no mul/div hold; rules 3-5 apply; next state RUN.
  - mem_req is ignored in MD_BUSY, since MEM is bubbled.
  - Resulting EX occupancy is exactly MULDIV_CYCLES cycles, with MULDIV_CYCLES-1 hold cycles.
- MEM_WAIT:
  - While !mem_ready: rule-1 outputs.
  - When mem_ready=1: that cycle behaves as RUN with rule 1 excluded; next state follows rules 2-5 (MD_BUSY or RUN).
- MULDIV_CYCLES=1: mul/div never stalls.
- Simultaneous events:
  - A mem stall masks both branch and load-use.
  - A branch masks load-use; the flushed ID instruction needs no stall.
  - ex_muldiv together with ex_branch_taken is illegal and not checked.
- stall_cnt increments every cycle in which pc_write_zero=1 and pc_src=0.
- Both counters saturate at 0xFFFF.
- cnt_clear has priority over increment; the counter reads 0 on the next cycle.

Test Plan:
- Reset then idle: all controls 0, stall_cnt=0, flush_cnt=0; reset asserted in MD_BUSY gives RUN and zero outputs the next cycle.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle with pc_write_zero=1, IF_pipeline_write_zero=1, id_ex_flush=1, stall_cnt=1. Repeating with ex_rd=0 gives no stall.
- Branch: ex_branch_taken=1, ex_branch_target=0x0040 -> same cycle pc_src=1, dest_pc=0x0040, both flushes=1, flush_cnt=1. A concurrent load-use gives no stall.
- Mul/div, MULDIV_CYCLES=4, ex_muldiv held high -> exactly 3 hold cycles with ex_mem_bubble=1, then release, RUN, stall_cnt=3.
- Mem wait: mem_req=1, mem_ready=0 for 3 cycles with ex_branch_taken=1 -> full freeze, pc_src=0 for 3 cycles. On mem_ready=1, pc_src=1 in that same cycle.
- Counter saturation: preload via 65535+ stall cycles -> stall_cnt stays 0xFFFF; cnt_clear -> 0.
